// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port sync-read RAM, with
// locked bursts capped at MAX_LOCK beats and registered read-valid routing.
module ram_port_arbiter #(
  parameter int AWIDTH   = 3,
  parameter int DWIDTH   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int CW = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [1:0]      rvalid_q, rvalid_d;

  logic [1:0]      req, we, lock, gnt, acc;
  logic            own;

  assign req  = {req1, req0};
  assign we   = {we1, we0};
  assign lock = {lock1, lock0};

  // Grant selection: round-robin in ARB, exclusive to the owner while locked.
  always_comb begin
    gnt = '0;
    unique case (state_q)
      ARB: begin
        if (req[0] && req[1]) gnt[rr_ptr_q] = 1'b1;
        else                  gnt = req;
      end
      LOCK0:   gnt[0] = req[0];
      LOCK1:   gnt[1] = req[1];
      default: gnt = '0;
    endcase
  end

  assign acc  = req & gnt;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (gnt[1]) begin
      ram_addr = addr1;
      ram_din  = wdata1;
      ram_we   = we1;
    end else if (gnt[0]) begin
      ram_addr = addr0;
      ram_din  = wdata0;
      ram_we   = we0;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    own        = 1'b0;
    unique case (state_q)
      ARB: begin
        lock_cnt_d = '0;
        if (acc != 2'b00) begin
          own      = acc[1];
          rr_ptr_d = ~own;
          // A cap of one beat makes every burst a single access.
          if (lock[own] && (MAX_LOCK > 1)) begin
            state_d    = own ? LOCK1 : LOCK0;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        own = (state_q == LOCK1);
        if (!req[own]) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          rr_ptr_d = ~own;
          if (lock[own] && ((lock_cnt_q + CW'(1)) < CW'(MAX_LOCK))) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Read data comes straight from the RAM; only the valid needs a flop.
  assign rvalid_d = acc & ~we;
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign rdata    = ram_dout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed vector bench for ram_port_arbiter with a behavioural sync-read RAM.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [2:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [2:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [8];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.AWIDTH(3), .DWIDTH(32), .MAX_LOCK(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Single-port, read-first RAM with a bench preload path.
  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        r0, w0, l0; logic [2:0] a0; logic [31:0] d0;
    logic        r1, w1, l1; logic [2:0] a1; logic [31:0] d1;
    logic        g0, g1, v0, v1; logic [31:0] rd; logic rwe; logic [2:0] ra;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  initial begin
    vec_t idle;
    idle = '{0,0,0,3'd0,32'h0, 0,0,0,3'd0,32'h0, 0,0,0,0,32'h0,0,3'd0};

    //       r0 w0 l0 a0 d0              r1 w1 l1 a1 d1              g0 g1 v0 v1 rd            rwe ra
    vt[0]  = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,0,0,32'h0,          0,3'd0};
    vt[1]  = '{1,0,0,3'd3,32'h0,         0,0,0,3'd0,32'h0,           1,0,0,0,32'h0,          0,3'd3};
    vt[2]  = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,1,0,32'hA5A5A5A5,   0,3'd0};
    vt[3]  = '{1,0,0,3'd1,32'h0,         1,0,0,3'd2,32'h0,           0,1,0,0,32'h0,          0,3'd2};
    vt[4]  = '{1,0,0,3'd1,32'h0,         1,0,0,3'd2,32'h0,           1,0,0,1,32'h10000002,   0,3'd1};
    vt[5]  = '{1,0,0,3'd1,32'h0,         1,0,0,3'd2,32'h0,           0,1,1,0,32'h10000001,   0,3'd2};
    vt[6]  = '{1,0,0,3'd1,32'h0,         1,0,0,3'd2,32'h0,           1,0,0,1,32'h10000002,   0,3'd1};
    vt[7]  = '{1,0,0,3'd0,32'h0,         1,1,1,3'd4,32'hC0000004,    0,1,1,0,32'h10000001,   1,3'd4};
    vt[8]  = '{1,0,0,3'd0,32'h0,         1,1,1,3'd5,32'hC0000005,    0,1,0,0,32'h0,          1,3'd5};
    vt[9]  = '{1,0,0,3'd0,32'h0,         1,1,1,3'd6,32'hC0000006,    0,1,0,0,32'h0,          1,3'd6};
    vt[10] = '{1,0,0,3'd0,32'h0,         1,1,1,3'd7,32'hC0000007,    0,1,0,0,32'h0,          1,3'd7};
    vt[11] = '{1,0,0,3'd0,32'h0,         1,1,1,3'd7,32'hC0000007,    1,0,0,0,32'h0,          0,3'd0};
    vt[12] = '{0,0,0,3'd0,32'h0,         1,0,0,3'd4,32'h0,           0,1,1,0,32'h10000000,   0,3'd4};
    vt[13] = '{0,0,0,3'd0,32'h0,         1,0,0,3'd7,32'h0,           0,1,0,1,32'hC0000004,   0,3'd7};
    vt[14] = '{1,0,0,3'd5,32'h0,         0,0,0,3'd0,32'h0,           1,0,0,1,32'hC0000007,   0,3'd5};
    vt[15] = '{0,0,0,3'd0,32'h0,         1,0,0,3'd6,32'h0,           0,1,1,0,32'hC0000005,   0,3'd6};
    vt[16] = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,0,1,32'hC0000006,   0,3'd0};
    vt[17] = '{0,0,0,3'd0,32'h0,         1,1,1,3'd1,32'hD0000001,    0,1,0,0,32'h0,          1,3'd1};
    vt[18] = '{1,0,0,3'd3,32'h0,         1,1,1,3'd2,32'hD0000002,    0,1,0,0,32'h0,          1,3'd2};
    vt[19] = '{1,0,0,3'd3,32'h0,         0,0,0,3'd0,32'h0,           0,0,0,0,32'h0,          0,3'd0};
    vt[20] = '{1,0,0,3'd3,32'h0,         0,0,0,3'd0,32'h0,           1,0,0,0,32'h0,          0,3'd3};
    vt[21] = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,1,0,32'hA5A5A5A5,   0,3'd0};
    vt[22] = '{1,1,0,3'd2,32'h12345678,  0,0,0,3'd0,32'h0,           1,0,0,0,32'h0,          1,3'd2};
    vt[23] = '{0,0,0,3'd0,32'h0,         1,0,0,3'd2,32'h0,           0,1,0,0,32'h0,          0,3'd2};
    vt[24] = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,0,1,32'h12345678,   0,3'd0};
    vt[25] = '{1,0,0,3'd1,32'h0,         0,0,0,3'd0,32'h0,           1,0,0,0,32'h0,          0,3'd1};
    vt[26] = '{0,0,0,3'd0,32'h0,         0,0,0,3'd0,32'h0,           0,0,1,0,32'hD0000001,   0,3'd0};

    reset_n = 1'b0;
    drive(idle);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      ld_en = 1'b1; ld_addr = 3'(i);
      ld_data = (i == 3) ? 32'hA5A5A5A5 : 32'h10000000 + 32'(i);
    end
    @(posedge clock); #1;
    ld_en = 1'b0;
    chk("reset_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("reset_rvalid1", {31'b0, rvalid1}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clock); #1;
      drive(vt[i]);
      @(negedge clock);
      chk($sformatf("v%0d_gnt0", i),    {31'b0, gnt0},    {31'b0, vt[i].g0});
      chk($sformatf("v%0d_gnt1", i),    {31'b0, gnt1},    {31'b0, vt[i].g1});
      chk($sformatf("v%0d_rvalid0", i), {31'b0, rvalid0}, {31'b0, vt[i].v0});
      chk($sformatf("v%0d_rvalid1", i), {31'b0, rvalid1}, {31'b0, vt[i].v1});
      chk($sformatf("v%0d_ram_we", i),  {31'b0, ram_we},  {31'b0, vt[i].rwe});
      chk($sformatf("v%0d_ram_addr", i), {29'b0, ram_addr}, {29'b0, vt[i].ra});
      if (vt[i].v0 || vt[i].v1)
        chk($sformatf("v%0d_rdata", i), rdata, vt[i].rd);
    end

    // Reset one cycle after a locked read accept: valid drops immediately,
    // the read is lost and arbitration restarts from ARB favouring req0.
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 3'd3;
    @(negedge clock);
    chk("rst_pre_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge clock); #1;
    chk("rst_pre_rvalid0", {31'b0, rvalid0}, 32'd1);
    drive(idle);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_now_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("rst_now_rvalid1", {31'b0, rvalid1}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_after_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("rst_after_rvalid1", {31'b0, rvalid1}, 32'd0);
    req0 = 1'b1; req1 = 1'b1; addr0 = 3'd5; addr1 = 3'd6;
    #1;
    chk("rst_rr_gnt0", {31'b0, gnt0}, 32'd1);
    chk("rst_rr_gnt1", {31'b0, gnt1}, 32'd0);
    req0 = 1'b0;
    #1;
    chk("rst_arb_gnt1", {31'b0, gnt1}, 32'd1);
    chk("rst_arb_addr", {29'b0, ram_addr}, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
